// File: rtl/keypad_scan_unit_if.sv
// Keypad matrix lines plus the debounced key report, shared by the scanner
// (master) and its consumer or keypad model (slave).
interface keypad_scan_unit_if;
  logic [3:0] row;
  logic [3:0] col;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;

  modport master (
    input  row,
    output col,
    output key_code,
    output key_valid,
    output key_held
  );

  modport slave (
    output row,
    input  col,
    input  key_code,
    input  key_valid,
    input  key_held
  );
endinterface

// File: rtl/keypad_scan_unit.sv
// 4x4 matrix keypad scanner: one active-low column per slot, frame-level
// debounce, hex key report with press strobe and held level.
module keypad_scan_unit #(
  parameter int SCAN_DIV  = 100000,
  parameter int DEB_SCANS = 4
) (
  input  logic                clk,
  input  logic                rst,
  keypad_scan_unit_if.master  kp
);

  localparam int                SLOT_W     = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [SLOT_W-1:0] SLOT_LAST  = SLOT_W'(SCAN_DIV - 1);
  localparam logic [3:0]        DEB_CNT    = 4'(DEB_SCANS);
  // Candidate: bit 4 set marks the non-key results.
  localparam logic [4:0]        CAND_NONE  = 5'h10;
  localparam logic [4:0]        CAND_MULTI = 5'h11;

  function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] code;
    case ({r, c})
      4'h0: code = 4'h1;  4'h1: code = 4'h2;  4'h2: code = 4'h3;  4'h3: code = 4'hA;
      4'h4: code = 4'h4;  4'h5: code = 4'h5;  4'h6: code = 4'h6;  4'h7: code = 4'hB;
      4'h8: code = 4'h7;  4'h9: code = 4'h8;  4'hA: code = 4'h9;  4'hB: code = 4'hC;
      4'hC: code = 4'h0;  4'hD: code = 4'hF;  4'hE: code = 4'hE;  4'hF: code = 4'hD;
      default: code = 4'h0;
    endcase
    return code;
  endfunction

  function automatic logic [2:0] popcount4(input logic [3:0] v);
    return {2'b00, v[0]} + {2'b00, v[1]} + {2'b00, v[2]} + {2'b00, v[3]};
  endfunction

  logic [SLOT_W-1:0] slot_r;
  logic [1:0]        col_idx_r;
  logic [1:0]        col_idx_next_s;
  logic [3:0]        col_r;
  logic [3:0]        sync1_r;
  logic [3:0]        sync2_r;
  logic [1:0]        frame_hits_r;
  logic [3:0]        frame_code_r;
  logic [4:0]        prev_r;
  logic [4:0]        stable_r;
  logic [3:0]        deb_cnt_r;
  logic [3:0]        key_code_r;
  logic              key_valid_r;
  logic              key_held_r;

  logic [3:0]        pressed_s;
  logic [2:0]        col_hits_s;
  logic [3:0]        col_code_s;
  logic [2:0]        sum_hits_s;
  logic [4:0]        cand_s;
  logic [1:0]        frame_hits_next_s;
  logic [3:0]        frame_code_next_s;
  logic [3:0]        deb_cnt_next_s;
  logic              accept_s;

  assign col_idx_next_s = col_idx_r + 2'd1;

  // Slot counter and column drive.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_r    <= '0;
      col_idx_r <= 2'd0;
      col_r     <= 4'b1110;
    end else if (slot_r == SLOT_LAST) begin
      slot_r    <= '0;
      col_idx_r <= col_idx_next_s;
      col_r     <= ~(4'b0001 << col_idx_next_s);
    end else begin
      slot_r    <= slot_r + SLOT_W'(1);
    end
  end

  // Two-flop row synchronizer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_r <= 4'b1111;
      sync2_r <= 4'b1111;
    end else begin
      sync1_r <= kp.row;
      sync2_r <= sync1_r;
    end
  end

  // Fold the current column sample into the frame result and debounce count.
  always_comb begin
    pressed_s         = ~sync2_r;
    col_hits_s        = popcount4(pressed_s);
    col_code_s        = 4'h0;
    if (pressed_s[0])      col_code_s = key_map(2'd0, col_idx_r);
    else if (pressed_s[1]) col_code_s = key_map(2'd1, col_idx_r);
    else if (pressed_s[2]) col_code_s = key_map(2'd2, col_idx_r);
    else if (pressed_s[3]) col_code_s = key_map(2'd3, col_idx_r);
    else                   col_code_s = 4'h0;

    sum_hits_s        = {1'b0, frame_hits_r} + col_hits_s;
    frame_code_next_s = (col_hits_s == 3'd1) ? col_code_s : frame_code_r;
    frame_hits_next_s = (sum_hits_s >= 3'd2) ? 2'd2 : sum_hits_s[1:0];

    if (sum_hits_s == 3'd0)      cand_s = CAND_NONE;
    else if (sum_hits_s == 3'd1) cand_s = {1'b0, frame_code_next_s};
    else                         cand_s = CAND_MULTI;

    if (cand_s != prev_r)          deb_cnt_next_s = 4'd1;
    else if (deb_cnt_r >= DEB_CNT) deb_cnt_next_s = DEB_CNT;
    else                           deb_cnt_next_s = deb_cnt_r + 4'd1;

    accept_s = (deb_cnt_next_s == DEB_CNT) && (cand_s != CAND_MULTI) && (cand_s != stable_r);
  end

  // Frame accumulation, debounce state and key report.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_hits_r <= 2'd0;
      frame_code_r <= 4'h0;
      prev_r       <= CAND_NONE;
      stable_r     <= CAND_NONE;
      deb_cnt_r    <= 4'd0;
      key_code_r   <= 4'h0;
      key_valid_r  <= 1'b0;
      key_held_r   <= 1'b0;
    end else begin
      key_valid_r <= 1'b0;
      if (slot_r == SLOT_LAST) begin
        if (col_idx_r != 2'd3) begin
          frame_hits_r <= frame_hits_next_s;
          frame_code_r <= frame_code_next_s;
        end else begin
          frame_hits_r <= 2'd0;
          frame_code_r <= 4'h0;
          prev_r       <= cand_s;
          deb_cnt_r    <= deb_cnt_next_s;
          if (accept_s) begin
            stable_r <= cand_s;
            if (cand_s == CAND_NONE) begin
              key_held_r  <= 1'b0;
            end else begin
              key_code_r  <= cand_s[3:0];
              key_held_r  <= 1'b1;
              key_valid_r <= 1'b1;
            end
          end
        end
      end
    end
  end

  assign kp.col       = col_r;
  assign kp.key_code  = key_code_r;
  assign kp.key_valid = key_valid_r;
  assign kp.key_held  = key_held_r;

endmodule
